sync_fifo_fwft: RTL and testbench
=================================

Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised-depth FIFO with first-word-fall-through (FWFT) output.
- Next generation of the team's FIFO:
  - keeps the valid/full input handshake and the valid/ack output handshake;
  - runs on one clock domain;
  - adds a fill-level output and programmable almost-full/almost-empty flags.
- Used as an elastic buffer between same-clock pipeline stages and as the building block for rate-smoothing in the datapath.

Parameters:
- BUFFER_SIZE, 127: number of storage entries; any integer ≥2, not required to be a power of two.
- DATA_WIDTH, 32: word width in bits.
- ALMOST_FULL_THRESH, 120: data_in_almost_full asserted when level ≥ this value; legal range 1..BUFFER_SIZE.
- ALMOST_EMPTY_THRESH, 4: data_out_almost_empty asserted when level ≤ this value; legal range 0..BUFFER_SIZE-1.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- data_in  in  DATA_WIDTH  write data.
- data_in_valid  in  1  write request.
- data_in_full  out  1  FIFO holds BUFFER_SIZE words; writes refused.
- data_in_almost_full  out  1  level ≥ ALMOST_FULL_THRESH.
- data_out  out  DATA_WIDTH  head-of-queue word (FWFT).
- data_out_valid  out  1  data_out holds a valid word.
- data_out_ack  in  1  consumer takes the word on data_out.
- data_out_almost_empty  out  1  level ≤ ALMOST_EMPTY_THRESH.
- level  out  $clog2(BUFFER_SIZE+1)  number of words held, including the word presented on data_out.

Behaviour:
- All outputs are registered; all state updates on the rising clock edge.
- Reset (rst_n=0 at an edge):
  - level=0, read/write pointers=0, data_out=0, data_out_valid=0;
  - data_in_full=0, data_in_almost_full=0, data_out_almost_empty=1.
  - Memory contents are not cleared.
  - Reset overrides all push/pop at that edge.
  - Reset mid-operation discards all stored words.
- Push:
  - Accepted when data_in_valid=1 and data_in_full=0 at the edge.
  - data_in is ignored when data_in_valid=0.
  - When data_in_full=1, the push is dropped and the FIFO is unchanged.
  - Full is evaluated on the registered flag, so a simultaneous pop while full does NOT admit the push that cycle.
- Pop:
  - Occurs when data_out_valid=1 and data_out_ack=1 at the edge.
  - data_out_ack with data_out_valid=0 is ignored.
- FWFT latency:
  - A word pushed into an empty FIFO at edge N appears on data_out with data_out_valid=1 after edge N (visible in cycle N+1).
  - After a pop, the next word is presented after the same edge; there are no bubbles while level>0.
- Simultaneous push and pop (both accepted):
  - level is unchanged.
  - At level=1, data_out takes the pushed word after the edge.
- Level update: level_next = level + push_accepted − pop.
  - data_in_full = (level_next == BUFFER_SIZE).
  - data_out_valid = (level_next != 0).
  - The almost flags are computed from level_next, so all flags are consistent with level every cycle.
- Pointers:
  - Range 0..BUFFER_SIZE-1.
  - Each pointer wraps from BUFFER_SIZE-1 to 0; no power-of-two assumption.
- data_out holds its last value when data_out_valid=0.

Optional Feature:
- Macro: FIFO_ERROR_FLAGS_EN.
- With the macro defined, two extra outputs follow level in the port list:
  - overflow_err (1 bit): sets on any edge with data_in_valid=1 and data_in_full=1.
  - underflow_err (1 bit): sets on any edge with data_out_ack=1 and data_out_valid=0.
  - Both are sticky and are cleared only by reset (reset value 0).
- Without the macro: the ports do not exist; overflow and underflow attempts are silently ignored as described above.

Test Plan:
- Reset then idle, BUFFER_SIZE=5, DATA_WIDTH=8: after reset, level=0, data_out_valid=0, data_out_almost_empty=1, data_in_full=0; all hold for 10 idle cycles.
- Single-word FWFT: push 0xA5 at edge N with no ack → data_out=0xA5, data_out_valid=1, level=1 in cycle N+1. Ack at edge N+1 → data_out_valid=0, level=0.
- Fill to full, BUFFER_SIZE=5: push 0x01..0x06 on consecutive cycles → 0x06 dropped, data_in_full=1, level=5. Drain with continuous ack → outputs 0x01..0x05 in order, with no gaps.
- Wrap-around, BUFFER_SIZE=5: 13 cycles of simultaneous push (values 0x10..0x1C) and pop at steady level=3 → output order is preserved across several pointer wraps, level stays 3.
- Thresholds, BUFFER_SIZE=5, ALMOST_FULL_THRESH=4, ALMOST_EMPTY_THRESH=1:
  - push 4 words → data_in_almost_full rises in the same cycle level reads 4;
  - pop 3 → data_out_almost_empty rises when level reads 1.
- Reset mid-operation with FIFO_ERROR_FLAGS_EN:
  - with level=3, push while data_in_full=1 earlier → overflow_err=1;
  - assert rst_n=0 for one edge together with data_in_valid=1 → level=0, data_out_valid=0, overflow_err=0, the pushed word is not stored.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FWFT FIFO with level and almost flags; FIFO_ERROR_FLAGS_EN adds sticky overflow/underflow flags
module sync_fifo_fwft #(
  parameter int BUFFER_SIZE         = 127,
  parameter int DATA_WIDTH          = 32,
  parameter int ALMOST_FULL_THRESH  = 120,
  parameter int ALMOST_EMPTY_THRESH = 4
) (
  input  logic                               clock,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               data_in_valid,
  output logic                               data_in_full,
  output logic                               data_in_almost_full,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_out_valid,
  input  logic                               data_out_ack,
  output logic                               data_out_almost_empty,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]   level
`ifdef FIFO_ERROR_FLAGS_EN
  ,
  output logic                               overflow_err,
  output logic                               underflow_err
`endif
);
  localparam int LW = $clog2(BUFFER_SIZE + 1);
  localparam int PW = $clog2(BUFFER_SIZE);
  logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic valid_q, valid_d, full_q, full_d, af_q, af_d, ae_q, ae_d;
  logic push, pop;
  always_comb begin
    push       = data_in_valid && !full_q;
    pop        = valid_q && data_out_ack;
    wr_ptr_d   = push ? ((wr_ptr_q == PW'(BUFFER_SIZE - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = pop ? ((rd_ptr_q == PW'(BUFFER_SIZE - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    // The incoming word becomes the head when nothing else survives this edge.
    data_out_d = (level_d == '0) ? data_out_q :
                 (push && level_q == LW'(pop)) ? data_in : mem[rd_ptr_d];
    valid_d    = level_d != '0;
    full_d     = level_d == LW'(BUFFER_SIZE);
    af_d       = level_d >= LW'(ALMOST_FULL_THRESH);
    ae_d       = level_d <= LW'(ALMOST_EMPTY_THRESH);
  end
  always_ff @(posedge clock) begin
    if (rst_n && push) mem[wr_ptr_q] <= data_in;
  end
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end
  assign data_in_full          = full_q;
  assign data_in_almost_full   = af_q;
  assign data_out              = data_out_q;
  assign data_out_valid        = valid_q;
  assign data_out_almost_empty = ae_q;
  assign level                 = level_q;
`ifdef FIFO_ERROR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  always_comb begin
    ovf_d = ovf_q || (data_in_valid && full_q);
    unf_d = unf_q || (data_out_ack && !valid_q);
  end
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
`else
  // Refused pushes and empty acks are already dropped by the push/pop qualifiers.
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: randomized and directed checks against a queue model of the FIFO
module tb_sync_fifo_fwft;
  localparam int BS = 5;
  localparam int DW = 8;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int LW = $clog2(BS + 1);
  localparam int VW = LW + DW + 4;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic data_in_valid = 1'b0;
  logic data_out_ack = 1'b0;
  logic data_in_full, data_in_almost_full, data_out_valid, data_out_almost_empty;
  logic [DW-1:0] data_out;
  logic [LW-1:0] level;
`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_err, underflow_err;
`endif
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_dout = '0;
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;
  logic [VW-1:0] act;

  sync_fifo_fwft #(.BUFFER_SIZE(BS), .DATA_WIDTH(DW), .ALMOST_FULL_THRESH(AF), .ALMOST_EMPTY_THRESH(AE)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_full(data_in_full),
    .data_in_almost_full(data_in_almost_full),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ack(data_out_ack),
    .data_out_almost_empty(data_out_almost_empty),
    .level(level)
`ifdef FIFO_ERROR_FLAGS_EN
    ,
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
`endif
  );

  always #5 clock = ~clock;
  assign act = {level, data_out_valid, data_out, data_in_full, data_in_almost_full, data_out_almost_empty};

  function automatic logic [VW-1:0] expv();
    int n = q.size();
    return {LW'(n), n > 0, exp_dout, n == BS, n >= AF, n <= AE};
  endfunction

  task automatic step(input logic rst, input logic v, input logic [DW-1:0] d, input logic a);
    bit push, pop;
    rst_n = ~rst;
    data_in_valid = v;
    data_in = d;
    data_out_ack = a;
    push = v && q.size() < BS;
    pop = a && q.size() > 0;
    if (v && q.size() == BS) exp_ovf = 1'b1;
    if (a && q.size() == 0) exp_unf = 1'b1;
    @(posedge clock);
    if (rst) begin
      q.delete();
      exp_dout = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (q.size() > 0) exp_dout = q[0];
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (act !== expv()) begin
        fails++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, act, expv());
      end
      step(0, 0, 8'($urandom), 0);
    end
  endtask

  task automatic test_single();
    step(0, 1, 8'hA5, 0);
    tests++;
    if (act !== expv() || data_out !== 8'hA5 || level !== LW'(1)) begin
      fails++;
      $display("FAIL single_push: got %h expected %h", act, expv());
    end
    step(0, 0, 8'h00, 1);
    tests++;
    if (act !== expv() || data_out_valid !== 1'b0 || level !== LW'(0)) begin
      fails++;
      $display("FAIL single_pop: got %h expected %h", act, expv());
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 8'(i), 0);
      tests++;
      if (act !== expv()) begin
        fails++;
        $display("FAIL fill[%0d]: got %h expected %h", i, act, expv());
      end
    end
    tests++;
    if (level !== LW'(5) || data_in_full !== 1'b1 || data_out !== 8'h01) begin
      fails++;
      $display("FAIL fill_full: got level %0d full %b head %h expected 5 1 01", level, data_in_full, data_out);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (data_out_valid !== 1'b1 || data_out !== 8'(i + 1)) begin
        fails++;
        $display("FAIL drain_order[%0d]: got %b/%h expected 1/%h", i, data_out_valid, data_out, 8'(i + 1));
      end
      step(0, 0, 8'h00, 1);
    end
    tests++;
    if (act !== expv() || data_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: got %h expected %h", act, expv());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hE0 + i), 0);
    for (int i = 0; i < 13; i++) begin
      step(0, 1, 8'(8'h10 + i), 1);
      tests++;
      if (act !== expv() || level !== LW'(3)) begin
        fails++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, act, expv());
      end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
  endtask

  task automatic test_thresholds();
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'(8'h40 + i), 0);
      tests++;
      if (act !== expv() || data_in_almost_full !== (i == 3)) begin
        fails++;
        $display("FAIL almost_full[%0d]: got %h expected %h", i, act, expv());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 1);
      tests++;
      if (act !== expv() || data_out_almost_empty !== (i == 2)) begin
        fails++;
        $display("FAIL almost_empty[%0d]: got %h expected %h", i, act, expv());
      end
    end
  endtask

  task automatic test_random();
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 600; i++) begin
      int mode = (i / 60) % 3;
      logic v = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      logic a = (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      step($urandom_range(0, 99) == 0, v, 8'($urandom), a);
      tests++;
      if (act !== expv()) begin
        fails++;
        $display("FAIL random[%0d]: got %h expected %h", i, act, expv());
      end
    end
  endtask

`ifdef FIFO_ERROR_FLAGS_EN
  task automatic test_errors();
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    tests++;
    if (underflow_err !== exp_unf || underflow_err !== 1'b1 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL underflow: got %b/%b expected 1/0", underflow_err, overflow_err);
    end
    for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h60 + i), 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    tests++;
    if (act !== expv() || level !== LW'(3) || overflow_err !== exp_ovf || overflow_err !== 1'b1) begin
      fails++;
      $display("FAIL overflow: got %h ovf %b expected %h ovf 1", act, overflow_err, expv());
    end
    step(1, 1, 8'h77, 0);
    tests++;
    if (act !== expv() || level !== LW'(0) || data_out_valid !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got %h ovf %b unf %b expected %h 0 0", act, overflow_err, underflow_err, expv());
    end
    step(0, 0, 8'h00, 0);
    tests++;
    if (act !== expv() || level !== LW'(0)) begin
      fails++;
      $display("FAIL reset_push_dropped: got %h expected %h", act, expv());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_thresholds();
    test_random();
`ifdef FIFO_ERROR_FLAGS_EN
    test_errors();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
